// File: rtl/mem_pkg.sv
// Shared encodings, the E/M pipeline register layout and access-legality helpers
// for the RV32 memory stage.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic            regWrite;
    logic [1:0]      resultSrc;
    logic            memWrite;
    logic [2:0]      memCtrl;
    logic [4:0]      rd;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] writeData;
    logic [XLEN-1:0] pcPlus4;
  } emReg_t;

  // Loads accept the unsigned variants; stores only B/H/W.
  function automatic logic loadLegal(input logic [2:0] ctrl, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      MEM_B, MEM_BU: ok = 1'b1;
      MEM_H, MEM_HU: ok = ~off[0];
      MEM_W:         ok = (off == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic storeLegal(input logic [2:0] ctrl, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      MEM_B:   ok = 1'b1;
      MEM_H:   ok = ~off[0];
      MEM_W:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-lane data memory: per-lane write enables on the clock edge, combinational word read.
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] wordIdx_i,
  input  logic [3:0]            byteEn_i,
  input  logic [XLEN-1:0]       wrData_i,
  output logic [XLEN-1:0]       rdData_o
);

  logic [3:0][7:0] memArray [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (byteEn_i[lane]) begin
        memArray[wordIdx_i][lane] <= wrData_i[8*lane +: 8];
      end
    end
  end

  assign rdData_o = memArray[wordIdx_i];

endmodule

// File: rtl/memory_stage.sv
// RV32 memory stage: E/M pipeline register with stall/flush, byte-addressable data
// memory access with extension, and a sticky misaligned-access flag.
module memory_stage
  import mem_pkg::*;
#(
  parameter int WIDTH      = XLEN,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             MemWriteE,
  input  logic [2:0]       MemCtrlE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [4:0]       RdE,
  input  logic [WIDTH-1:0] PCPlus4E,
  output logic             RegWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [4:0]       RdM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             MisalignErr
);

  emReg_t emD, emQ;
  logic   errD, errQ;

  logic [1:0]            byteOff;
  logic [DEPTH_LOG2-1:0] wordIdx;
  logic [WIDTH-1:0]      rawWord;
  logic [WIDTH-1:0]      laneData;
  logic [WIDTH-1:0]      loadData;
  logic [3:0]            byteEn;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;
  logic                  loadOk, storeOk, isLoad, isStore;

  // Flush beats stall so a bubble can always be injected.
  always_comb begin
    emD = emQ;
    if (flush) begin
      emD = '0;
    end else if (!stall) begin
      emD.regWrite  = RegWriteE;
      emD.resultSrc = ResultSrcE;
      emD.memWrite  = MemWriteE;
      emD.memCtrl   = MemCtrlE;
      emD.rd        = RdE;
      emD.aluResult = ALUResultE;
      emD.writeData = WriteDataE;
      emD.pcPlus4   = PCPlus4E;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emQ  <= '0;
      errQ <= 1'b0;
    end else begin
      emQ  <= emD;
      errQ <= errD;
    end
  end

  assign byteOff = emQ.aluResult[1:0];
  assign wordIdx = emQ.aluResult[DEPTH_LOG2+1:2];
  assign loadOk  = loadLegal(emQ.memCtrl, byteOff);
  assign storeOk = storeLegal(emQ.memCtrl, byteOff);
  assign isLoad  = emQ.regWrite && (emQ.resultSrc == RES_MEM);
  assign isStore = emQ.memWrite;
  assign errD    = errQ | (isLoad & ~loadOk) | (isStore & ~storeOk);

  always_comb begin
    byteEn   = 4'b0000;
    laneData = emQ.writeData;
    case (emQ.memCtrl)
      MEM_B: begin
        byteEn   = 4'b0001 << byteOff;
        laneData = {4{emQ.writeData[7:0]}};
      end
      MEM_H: begin
        byteEn   = byteOff[1] ? 4'b1100 : 4'b0011;
        laneData = {2{emQ.writeData[15:0]}};
      end
      MEM_W:   byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
    if (!(isStore && storeOk)) begin
      byteEn = 4'b0000;
    end
  end

  data_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_dataMem (
    .clk      (clk),
    .wordIdx_i(wordIdx),
    .byteEn_i (byteEn),
    .wrData_i (laneData),
    .rdData_o (rawWord)
  );

  assign byteSel = rawWord[{byteOff, 3'b000} +: 8];
  assign halfSel = rawWord[{byteOff[1], 4'b0000} +: 16];

  always_comb begin
    loadData = '0;
    if (loadOk) begin
      case (emQ.memCtrl)
        MEM_B:   loadData = {{(WIDTH-8){byteSel[7]}}, byteSel};
        MEM_H:   loadData = {{(WIDTH-16){halfSel[15]}}, halfSel};
        MEM_W:   loadData = rawWord;
        MEM_BU:  loadData = {{(WIDTH-8){1'b0}}, byteSel};
        MEM_HU:  loadData = {{(WIDTH-16){1'b0}}, halfSel};
        default: loadData = '0;
      endcase
    end
  end

  assign RegWriteM   = emQ.regWrite;
  assign ResultSrcM  = emQ.resultSrc;
  assign RdM         = emQ.rd;
  assign ALUResultM  = emQ.aluResult;
  assign PCPlus4M    = emQ.pcPlus4;
  assign ReadDataM   = loadData;
  assign MisalignErr = errQ;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expectations from a byte-array
// reference model, an independent monitor pops and compares after each clock edge.
module tb_memory_stage;

  localparam int DEPTH_LOG2 = 10;
  localparam int MEM_BYTES  = 4 << DEPTH_LOG2;

  typedef struct {
    bit        rw;
    bit [1:0]  rs;
    bit        mw;
    bit [2:0]  ctrl;
    bit [31:0] alu;
    bit [31:0] wd;
    bit [31:0] pc4;
    bit [4:0]  rd;
  } instT;

  typedef struct {
    bit        rw;
    bit [1:0]  rs;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit [31:0] pc4;
    bit [31:0] rdata;
    bit        err;
  } expT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        RegWriteE = 1'b0, MemWriteE = 1'b0;
  logic [1:0]  ResultSrcE = '0;
  logic [2:0]  MemCtrlE = '0;
  logic [31:0] ALUResultE = '0, WriteDataE = '0, PCPlus4E = '0;
  logic [4:0]  RdE = '0;
  logic        RegWriteM, MisalignErr;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM;

  memory_stage #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .MemCtrlE(MemCtrlE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .RdE(RdE), .PCPlus4E(PCPlus4E),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
    .MisalignErr(MisalignErr)
  );

  always #5 clk = ~clk;

  bit [7:0] mm [MEM_BYTES];
  instT     curM;
  bit       errModel = 1'b0;
  expT      expQ [$];
  int       total = 0;
  int       bad = 0;

  function automatic int accessBytes(bit [2:0] ctrl);
    case (ctrl)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit loadOk(bit [2:0] ctrl, bit [31:0] addr);
    int n = accessBytes(ctrl);
    return (n != 0) && ((int'(addr[1:0]) % n) == 0);
  endfunction

  function automatic bit storeOk(bit [2:0] ctrl, bit [31:0] addr);
    return (ctrl <= 3'd2) && loadOk(ctrl, addr);
  endfunction

  function automatic bit [31:0] modelLoad(bit [2:0] ctrl, bit [31:0] addr);
    int        a = int'(addr) & (MEM_BYTES - 1);
    int        n = accessBytes(ctrl);
    bit [31:0] v = 0;
    if (!loadOk(ctrl, addr)) return 32'd0;
    for (int i = 0; i < n; i++) v = v + (32'(mm[a + i]) << (8 * i));
    if (ctrl == 3'd0 && v >= 128)   v = v - 256;
    if (ctrl == 3'd1 && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic instT mkInst(bit rw, bit [1:0] rs, bit mw, bit [2:0] ctrl,
                                  bit [31:0] alu, bit [31:0] wd);
    instT e;
    e.rw = rw; e.rs = rs; e.mw = mw; e.ctrl = ctrl; e.alu = alu; e.wd = wd;
    e.pc4 = $urandom; e.rd = 5'($urandom);
    return e;
  endfunction

  function automatic instT mkLoad(bit [2:0] ctrl, bit [31:0] addr);
    return mkInst(1'b1, 2'b01, 1'b0, ctrl, addr, $urandom);
  endfunction

  function automatic instT mkStore(bit [2:0] ctrl, bit [31:0] addr, bit [31:0] data);
    return mkInst(1'b0, 2'b00, 1'b1, ctrl, addr, data);
  endfunction

  function automatic instT randInst();
    int        kind = $urandom_range(0, 9);
    bit [2:0]  ctrl;
    bit [31:0] alu = $urandom;
    bit [2:0]  loadCodes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (kind <= 3) begin
      ctrl = ($urandom_range(0, 19) == 0) ? 3'd3 : loadCodes[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) != 0 && accessBytes(ctrl) != 0) alu = alu & ~32'(accessBytes(ctrl) - 1);
      return mkLoad(ctrl, alu);
    end else if (kind <= 6) begin
      ctrl = ($urandom_range(0, 19) == 0) ? 3'd4 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) != 0 && ctrl <= 3'd2) alu = alu & ~32'(accessBytes(ctrl) - 1);
      return mkStore(ctrl, alu, $urandom);
    end else if (kind <= 8) begin
      return mkInst(1'b1, (kind == 7) ? 2'b00 : 2'b10, 1'b0, 3'd0, alu, $urandom);
    end
    return mkInst(1'b0, 2'b00, 1'b0, 3'd0, alu, $urandom);
  endfunction

  function automatic void pushExpect();
    expT x;
    x.rw = curM.rw; x.rs = curM.rs; x.rd = curM.rd; x.alu = curM.alu;
    x.pc4 = curM.pc4; x.rdata = modelLoad(curM.ctrl, curM.alu); x.err = errModel;
    expQ.push_back(x);
  endfunction

  // One clock edge of the model: the access already in M takes effect, then M updates.
  function automatic void modelEdge(bit st, bit fl, instT e);
    int a = int'(curM.alu) & (MEM_BYTES - 1);
    if (curM.mw && storeOk(curM.ctrl, curM.alu)) begin
      for (int i = 0; i < accessBytes(curM.ctrl); i++) mm[a + i] = curM.wd[8*i +: 8];
    end
    if ((curM.mw && !storeOk(curM.ctrl, curM.alu)) ||
        (curM.rw && curM.rs == 2'b01 && !loadOk(curM.ctrl, curM.alu))) errModel = 1'b1;
    if (fl) curM = mkInst(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0);
    else if (!st) curM = e;
    if (fl) begin curM.rd = 5'd0; curM.pc4 = 32'd0; end
    pushExpect();
  endfunction

  task automatic driveE(instT e);
    RegWriteE = e.rw; ResultSrcE = e.rs; MemWriteE = e.mw; MemCtrlE = e.ctrl;
    ALUResultE = e.alu; WriteDataE = e.wd; RdE = e.rd; PCPlus4E = e.pc4;
  endtask

  task automatic applyStimulus(bit st, bit fl, instT e);
    @(negedge clk);
    rst_n = 1'b1;
    stall = st;
    flush = fl;
    driveE(e);
    modelEdge(st, fl, e);
  endtask

  task automatic applyReset();
    instT junk = mkStore(3'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    junk.rw = 1'b1; junk.rs = 2'b11; junk.rd = 5'd31;
    @(negedge clk);
    driveE(junk);
    stall = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    curM = mkInst(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0);
    curM.rd = 5'd0; curM.pc4 = 32'd0;
    errModel = 1'b0;
    pushExpect();
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    expT x;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        checkOutput("RegWriteM", 32'(RegWriteM), 32'(x.rw));
        checkOutput("ResultSrcM", 32'(ResultSrcM), 32'(x.rs));
        checkOutput("RdM", 32'(RdM), 32'(x.rd));
        checkOutput("ALUResultM", ALUResultM, x.alu);
        checkOutput("PCPlus4M", PCPlus4M, x.pc4);
        checkOutput("MisalignErr", 32'(MisalignErr), 32'(x.err));
        if (x.rs == 2'b01) checkOutput("ReadDataM", ReadDataM, x.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    applyReset();

    for (int i = 0; i < (1 << DEPTH_LOG2); i++) applyStimulus(1'b0, 1'b0, mkStore(3'd2, 32'(i * 4), $urandom));

    applyStimulus(1'b0, 1'b0, mkStore(3'd2, 32'h100, 32'hDEADBEEF));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h100));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd0, 32'h103));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd4, 32'h103));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd1, 32'h102));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd5, 32'h100));
    applyStimulus(1'b0, 1'b0, mkStore(3'd0, 32'h101, 32'h0000_0055));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h100));
    applyStimulus(1'b0, 1'b0, mkStore(3'd1, 32'h102, 32'h0000_1234));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h100));

    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h100));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, randInst());
    applyStimulus(1'b1, 1'b1, mkStore(3'd2, 32'h100, 32'h2222_2222));
    applyStimulus(1'b0, 1'b1, mkStore(3'd2, 32'h100, 32'h1111_1111));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h100));

    applyStimulus(1'b0, 1'b0, mkStore(3'd2, 32'h1000, 32'hA5A5A5A5));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h0));

    applyStimulus(1'b0, 1'b0, mkStore(3'd2, 32'h104, 32'h7777_7777));
    applyReset();
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h104));

    applyStimulus(1'b0, 1'b0, mkStore(3'd2, 32'h102, 32'hCAFEF00D));
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h100));
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'(i * 4)));
      else applyStimulus(1'b0, 1'b0, mkStore(3'd0, 32'(i * 4 + 1), $urandom));
    end
    applyStimulus(1'b0, 1'b0, mkLoad(3'd2, 32'h101));

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, randInst());
    end
    applyStimulus(1'b0, 1'b0, mkInst(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0));

    repeat (2) @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory stage of the 5-stage RV32 pipeline. Sits directly downstream of the execute stage.
- Owns the execute-to-memory pipeline register, with stall and flush (bubble) control.
- Owns the byte-addressable data memory: byte, half and word loads/stores, sign/zero extension, misalignment detection.
- Feeds the writeback stage's register and presents M-stage values to the hazard/forwarding unit.

Parameters:
- WIDTH, 32, datapath width.
- DEPTH_LOG2, 10, log2 of data memory depth in 32-bit words (default 1024 words = 4 KiB).

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold E/M register contents.
- flush  in  1  load a bubble into the E/M register.
- RegWriteE  in  1  register-file write enable from execute.
- ResultSrcE  in  2  writeback mux select from execute.
- MemWriteE  in  1  store enable from execute.
- MemCtrlE  in  3  access size/sign, RV32 funct3 encoding.
- ALUResultE  in  WIDTH  effective address / ALU result.
- WriteDataE  in  WIDTH  store data (rs2).
- RdE  in  5  destination register.
- PCPlus4E  in  WIDTH  link value.
- RegWriteM  out  1  registered RegWriteE.
- ResultSrcM  out  2  registered ResultSrcE.
- RdM  out  5  registered RdE.
- ALUResultM  out  WIDTH  registered address/result; also the forwarding source.
- PCPlus4M  out  WIDTH  registered link value.
- ReadDataM  out  WIDTH  extended load data, combinational from the M register.
- MisalignErr  out  1  sticky misaligned/illegal-access flag.

Behaviour:
- Reset (rst_n low, async): every E/M register field clears to 0, so all M outputs read 0 and MisalignErr = 0. Memory array contents are not reset.
- Register update at posedge clk, by priority:
  - flush: control fields (RegWrite, ResultSrc, MemWrite, MemCtrl) and RdM clear to 0; data fields clear to 0.
  - else stall: all fields hold.
  - else: capture the E inputs.
- flush and stall asserted together: flush wins.
- Addressing:
  - Word index = ALUResultM[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2.
  - Byte offset = ALUResultM[1:0].
- Store (MemWriteM = 1) writes at the posedge after the store enters M; little-endian byte lanes:
  - MemCtrl 000 SB: writes lane offset with WriteData[7:0].
  - MemCtrl 001 SH: writes lanes offset and offset+1 with WriteData[15:0]; legal offset 0 or 2.
  - MemCtrl 010 SW: writes all lanes; legal offset 0 only.
  - Misaligned store or other MemCtrl code: write suppressed, MisalignErr set.
- Stalled store: the write re-executes each stalled cycle with identical data (idempotent, allowed).
- Load (ResultSrcM = 01) reads asynchronously; ReadDataM is valid in the same cycle the load is in M. Result is extracted from the lane at the offset:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended halfword.
- Misaligned LH/LHU/LW or illegal code: ReadDataM = 0, MisalignErr set.
- ReadDataM is don't-care when ResultSrcM ≠ 01; the implementation drives the decoded value anyway.
- Same-address ordering: a load in the cycle after a store returns the new data (write lands at the posedge, read is combinational after it).
- MisalignErr is set at the posedge where an offending access sits in M with RegWriteM or MemWriteM asserted. It is sticky until rst_n.
- Reset asserted mid-store: MemWriteM clears asynchronously; no write occurs on any later edge.

Decomposition:
- Package mem_pkg:
  - MemCtrl funct3 constants: MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU.
  - ResultSrc encodings: RES_ALU = 00, RES_MEM = 01, RES_PC4 = 10.
  - typedef of the E/M register struct.
- Sub-module data_mem: byte-lane memory array with a 4-bit byte-enable write and a combinational word read. memory_stage owns lane/enable generation, extension, the misalignment check and the pipeline register.

Test Plan:
- Reset: drive inputs nonzero with rst_n low → all M outputs 0, MisalignErr 0; rst_n released mid-cycle → no write occurs.
- Word and byte: SW 0xDEADBEEF to 0x100, then LW 0x100 → 0xDEADBEEF; LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE; LH 0x102 → 0xFFFFDEAD; LHU 0x100 → 0x0000BEEF.
- Partial store: SB 0x55 to 0x101 over 0xDEADBEEF, then LW 0x100 → 0xDEAD55EF; SH 0x1234 to 0x102 → LW 0x12345 5EF, i.e. 0x123455EF.
- Misaligned: SW to 0x102 → memory unchanged, MisalignErr rises the next edge and stays high through 10 legal accesses; LW 0x101 → ReadDataM 0.
- Stall/flush: stall during a load → outputs held 3 cycles; flush with stall → RegWriteM 0, MemWriteM 0, RdM 0; flush during a store → no memory change.
- Wrap: with DEPTH_LOG2 = 10, SW 0xA5A5A5A5 to 0x1000 → LW 0x0 returns 0xA5A5A5A5.
